// File: rtl/sqrt_iter_ctrl.sv
// Iterative unsigned integer square root, one result bit per clock.
// Start/done handshake, optional round-to-nearest, synchronous abort, back-to-back starts.
module sqrt_iter_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               start,
    input  logic               abort,
    input  logic               round_en,
    input  logic [WIDTH-1:0]   operand,
    output logic               busy,
    output logic               done,
    output logic [WIDTH/2:0]   root,
    output logic [WIDTH/2:0]   rem,
    output logic [1:0]         state
);

    localparam int ROOT_W = WIDTH / 2;
    localparam int CW     = $clog2(ROOT_W);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      opSr_q;
    logic [ROOT_W-1:0]     pr_q;
    logic [ROOT_W-1:0]     pq_q;
    logic [CW-1:0]         cnt_q;
    logic                  rnd_q;
    logic [ROOT_W:0]       root_q;
    logic [ROOT_W:0]       rem_q;

    logic [ROOT_W+1:0]     trialRem;
    logic [ROOT_W+1:0]     trialSub;
    logic [ROOT_W+1:0]     prIter;
    logic [ROOT_W-1:0]     pqIter;
    logic                  takeBit;
    logic [ROOT_W:0]       rootFinal;
    logic                  accept;
    logic                  step;
    logic                  finish;

    assign accept = ((state_q == IDLE) || (state_q == DONE)) && start;
    assign step   = (state_q == ITER) && !abort;
    assign finish = step && (cnt_q == '0);

    // One restoring iteration. Only the low ROOT_W bits of the partial remainder
    // ever reach the next trial, so only those are kept between iterations.
    always_comb begin
        trialRem  = {pr_q, opSr_q[WIDTH-1:WIDTH-2]};
        trialSub  = {pq_q, 2'b01};
        takeBit   = (trialRem >= trialSub);
        prIter    = takeBit ? (trialRem - trialSub) : trialRem;
        pqIter    = {pq_q[ROOT_W-2:0], takeBit};
        rootFinal = {1'b0, pqIter};
        if (rnd_q && (prIter > {2'b00, pqIter})) begin
            rootFinal = {1'b0, pqIter} + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = ITER;
            ITER: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = start ? ITER : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != IDLE);
        done  = (state_q == DONE);
        state = state_q;
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            opSr_q <= '0;
            pr_q   <= '0;
            pq_q   <= '0;
            cnt_q  <= '0;
            rnd_q  <= 1'b0;
        end else if (accept) begin
            opSr_q <= operand;
            pr_q   <= '0;
            pq_q   <= '0;
            cnt_q  <= CW'(ROOT_W - 1);
            rnd_q  <= round_en;
        end else if (step) begin
            opSr_q <= opSr_q << 2;
            pr_q   <= prIter[ROOT_W-1:0];
            pq_q   <= pqIter;
            cnt_q  <= cnt_q - CW'(1);
        end
    end

    // Results only change on a completed final iteration; an abort leaves them intact.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            root_q <= '0;
            rem_q  <= '0;
        end else if (finish) begin
            root_q <= rootFinal;
            rem_q  <= prIter[ROOT_W:0];
        end
    end

    assign root = root_q;
    assign rem  = rem_q;

endmodule

// File: tb/tb_sqrt_iter_ctrl.sv
// Self-checking bench for sqrt_iter_ctrl: directed scenarios at WIDTH=16,
// exhaustive WIDTH=8 and random WIDTH=32 against an arithmetic reference.
module tb_sqrt_iter_ctrl;

    logic clk = 1'b0;
    logic clear = 1'b1;

    logic        start16 = 1'b0, abort16 = 1'b0, rnd16 = 1'b0;
    logic [15:0] op16 = '0;
    logic        busy16, done16;
    logic [8:0]  root16, rem16;
    logic [1:0]  state16;

    logic        start8 = 1'b0, rnd8 = 1'b0;
    logic [7:0]  op8 = '0;
    logic        busy8, done8;
    logic [4:0]  root8, rem8;
    logic [1:0]  state8;

    logic        start32 = 1'b0, rnd32 = 1'b0;
    logic [31:0] op32 = '0;
    logic        busy32, done32;
    logic [16:0] root32, rem32;
    logic [1:0]  state32;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    sqrt_iter_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .clear(clear), .start(start16), .abort(abort16), .round_en(rnd16),
        .operand(op16), .busy(busy16), .done(done16), .root(root16), .rem(rem16), .state(state16)
    );

    sqrt_iter_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .clear(clear), .start(start8), .abort(1'b0), .round_en(rnd8),
        .operand(op8), .busy(busy8), .done(done8), .root(root8), .rem(rem8), .state(state8)
    );

    sqrt_iter_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .clear(clear), .start(start32), .abort(1'b0), .round_en(rnd32),
        .operand(op32), .busy(busy32), .done(done32), .root(root32), .rem(rem32), .state(state32)
    );

    // Reference: largest r with r*r <= x, found by binary search on plain integers.
    function automatic longint isqrt(input longint x);
        longint lo = 0;
        longint hi = 65536;
        longint mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= x) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    function automatic longint modelRoot(input longint x, input bit r);
        longint q = isqrt(x);
        if (r && (x - q * q) > q) q = q + 1;
        return q;
    endfunction

    // Drives one start pulse on dut16 and watches the following 14 cycles.
    task automatic applyStimulus(input logic [15:0] x, input logic r,
                                 output logic [8:0] rootOut, output logic [8:0] remOut,
                                 output int doneCyc, output int busyCnt, output int doneCnt);
        @(negedge clk);
        op16 = x; rnd16 = r; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        doneCyc = -1; busyCnt = 0; doneCnt = 0; rootOut = '0; remOut = '0;
        for (int i = 0; i < 14; i++) begin
            if (busy16) busyCnt++;
            if (done16) begin
                doneCnt++;
                if (doneCyc < 0) begin
                    doneCyc = i; rootOut = root16; remOut = rem16;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy16, done16, state16, root16, rem16} !== '0)
            $display("[TB] FAIL reset_outputs got busy=%0b done=%0b state=%0d root=%0d rem=%0d want all 0",
                     busy16, done16, state16, root16, rem16);
        else passes++;
        op16 = 16'd144; start16 = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy16, state16} !== '0)
            $display("[TB] FAIL reset_holds got busy=%0b state=%0d want 0 0", busy16, state16);
        else passes++;
        start16 = 1'b0;
        @(negedge clk);
        clear = 1'b1;
    endtask

    task automatic test_truncate();
        logic [15:0] xs [3]  = '{16'd0, 16'd16, 16'd65535};
        logic [8:0]  rts [3] = '{9'd0, 9'd4, 9'd255};
        logic [8:0]  rms [3] = '{9'd0, 9'd0, 9'd510};
        logic [8:0]  r, m;
        int dc, bc, nc;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(xs[k], 1'b0, r, m, dc, bc, nc);
            checks++;
            if (r !== rts[k]) $display("[TB] FAIL trunc_root x=%0d got %0d want %0d", xs[k], r, rts[k]);
            else passes++;
            checks++;
            if (m !== rms[k]) $display("[TB] FAIL trunc_rem x=%0d got %0d want %0d", xs[k], m, rms[k]);
            else passes++;
            checks++;
            if (dc !== 8) $display("[TB] FAIL latency x=%0d got %0d want 8", xs[k], dc);
            else passes++;
            checks++;
            if (bc !== 9 || nc !== 1) $display("[TB] FAIL busy_span x=%0d got busy=%0d dones=%0d want 9 1", xs[k], bc, nc);
            else passes++;
        end
    endtask

    task automatic test_round();
        logic [15:0] xs [3]  = '{16'd20, 16'd21, 16'd65535};
        logic [8:0]  rts [3] = '{9'd4, 9'd5, 9'd256};
        logic [8:0]  rms [3] = '{9'd4, 9'd5, 9'd510};
        logic [8:0]  r, m;
        int dc, bc, nc;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(xs[k], 1'b1, r, m, dc, bc, nc);
            checks++;
            if (r !== rts[k] || m !== rms[k] || dc !== 8)
                $display("[TB] FAIL round x=%0d got root=%0d rem=%0d at %0d want %0d %0d at 8",
                         xs[k], r, m, dc, rts[k], rms[k]);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        int doneAt [$];
        logic [8:0] rts [$];
        logic [8:0] rms [$];
        int idle = 0;
        logic [1:0] st9 = '0;
        @(negedge clk);
        op16 = 16'd100; rnd16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        op16 = 16'd2;
        for (int i = 0; i < 25; i++) begin
            if (done16) begin doneAt.push_back(i); rts.push_back(root16); rms.push_back(rem16); end
            if (i <= 17 && !busy16) idle++;
            if (i == 8) abort16 = 1'b1;
            if (i == 9) begin st9 = state16; start16 = 1'b0; abort16 = 1'b0; end
            @(negedge clk);
        end
        checks++;
        if (doneAt.size() != 2 || doneAt[0] != 8 || doneAt[1] != 17)
            $display("[TB] FAIL b2b_done_count got %0d dones want 2 at 8,17", doneAt.size());
        else passes++;
        checks++;
        if (rts.size() < 2 || rts[0] !== 9'd10 || rms[0] !== 9'd0 || rts[1] !== 9'd1 || rms[1] !== 9'd1)
            $display("[TB] FAIL b2b_results got %0d results want 10/0 then 1/1", rts.size());
        else passes++;
        checks++;
        if (idle != 0 || st9 !== 2'b01)
            $display("[TB] FAIL b2b_no_gap got idle=%0d state=%0d want 0 1", idle, st9);
        else passes++;
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        int firstAt = -1;
        logic [8:0] r = '0, m = '0;
        @(negedge clk);
        op16 = 16'd81; rnd16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (done16) begin
                dones++;
                if (firstAt < 0) begin firstAt = i; r = root16; m = rem16; end
            end
            if (i == 2) begin start16 = 1'b1; op16 = 16'd50; end
            if (i == 3) start16 = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (dones != 1 || firstAt != 8 || r !== 9'd9 || m !== 9'd0)
            $display("[TB] FAIL start_ignored got dones=%0d at %0d root=%0d rem=%0d want 1 at 8 9 0",
                     dones, firstAt, r, m);
        else passes++;
    endtask

    task automatic test_abort();
        int dones = 0;
        logic [1:0] st = 2'b11;
        logic [8:0] r, m;
        int dc, bc, nc;
        @(negedge clk);
        op16 = 16'd1000; rnd16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (done16) dones++;
            if (i == 4) abort16 = 1'b1;
            if (i == 5) begin st = state16; abort16 = 1'b0; end
            @(negedge clk);
        end
        checks++;
        if (st !== 2'b00 || dones != 0)
            $display("[TB] FAIL abort_state got state=%0d dones=%0d want 0 0", st, dones);
        else passes++;
        checks++;
        if (root16 !== 9'd9 || rem16 !== 9'd0)
            $display("[TB] FAIL abort_keeps got root=%0d rem=%0d want 9 0", root16, rem16);
        else passes++;
        applyStimulus(16'd1000, 1'b0, r, m, dc, bc, nc);
        checks++;
        if (r !== 9'd31 || m !== 9'd39 || dc !== 8)
            $display("[TB] FAIL abort_restart got root=%0d rem=%0d at %0d want 31 39 at 8", r, m, dc);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [8:0] r, m;
        int dc, bc, nc;
        @(negedge clk);
        op16 = 16'd65535; rnd16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (3) @(negedge clk);
        #2 clear = 1'b0;
        #1;
        checks++;
        if ({busy16, done16, state16, root16, rem16} !== '0)
            $display("[TB] FAIL reset_mid got busy=%0b done=%0b state=%0d root=%0d rem=%0d want all 0",
                     busy16, done16, state16, root16, rem16);
        else passes++;
        @(negedge clk);
        clear = 1'b1;
        applyStimulus(16'd144, 1'b0, r, m, dc, bc, nc);
        checks++;
        if (r !== 9'd12 || m !== 9'd0 || dc !== 8)
            $display("[TB] FAIL reset_restart got root=%0d rem=%0d at %0d want 12 0 at 8", r, m, dc);
        else passes++;
    endtask

    task automatic test_sweep8();
        longint expRoot, expRem;
        bit seen;
        for (int x = 0; x < 256; x++) begin
            for (int rb = 0; rb < 2; rb++) begin
                @(negedge clk);
                op8 = 8'(x); rnd8 = rb[0]; start8 = 1'b1;
                @(negedge clk);
                start8 = 1'b0;
                seen = 1'b0;
                for (int i = 0; i < 8 && !seen; i++) begin
                    if (done8) seen = 1'b1;
                    else @(negedge clk);
                end
                expRoot = modelRoot(longint'(x), rb[0]);
                expRem  = longint'(x) - isqrt(longint'(x)) * isqrt(longint'(x));
                checks++;
                if (!seen || longint'(root8) != expRoot || longint'(rem8) != expRem)
                    $display("[TB] FAIL sweep8 x=%0d rnd=%0d got done=%0b root=%0d rem=%0d want %0d %0d",
                             x, rb, seen, root8, rem8, expRoot, expRem);
                else passes++;
            end
        end
    endtask

    task automatic test_sweep32();
        longint x, q, expRoot, expRem;
        bit seen;
        bit r;
        for (int k = 0; k < 200; k++) begin
            x = (k == 0) ? 64'hFFFF_FFFF : (k == 1) ? 64'd0 : longint'($urandom);
            r = (k < 2) ? 1'b1 : bit'($urandom_range(0, 1));
            @(negedge clk);
            op32 = 32'(x); rnd32 = r; start32 = 1'b1;
            @(negedge clk);
            start32 = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                if (done32) seen = 1'b1;
                else @(negedge clk);
            end
            q = isqrt(x);
            expRoot = modelRoot(x, r);
            expRem  = x - q * q;
            checks++;
            if (!seen || longint'(root32) != expRoot || longint'(rem32) != expRem)
                $display("[TB] FAIL sweep32 x=%0d rnd=%0d got done=%0b root=%0d rem=%0d want %0d %0d",
                         x, r, seen, root32, rem32, expRoot, expRem);
            else passes++;
        end
    endtask

    initial begin
        #1 clear = 1'b0;
        test_reset();
        test_truncate();
        test_round();
        test_back_to_back();
        test_start_ignored();
        test_abort();
        test_reset_mid();
        test_sweep8();
        test_sweep32();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
